// File: rtl/target_cmd_pkg.sv
// Shared types and constants for the target command mailbox: FSM states, bridge signatures and word map.
package target_cmd_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    POSTED = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [15:0] CMD_SIG        = 16'h636D;
  localparam logic [15:0] ACK_SIG        = 16'h6F6B;
  localparam logic [15:0] RESULT_TIMEOUT = 16'hFFFF;

  // Word indices as seen on addr[7:2]
  localparam logic [5:0] WORD_STATUS = 6'h00;
  localparam logic [5:0] WORD_PARAM0 = 6'h01;
  localparam logic [5:0] WORD_RESP0  = 6'h20;
  localparam logic [5:0] WORD_RESP1  = 6'h21;

endpackage

// File: rtl/target_cmd_timer.sv
// Host-acknowledge watchdog: cleared by start, counts while run, expired flags count == TIMEOUT_CYCLES-1.
// Zero-latency expired output; no backpressure.
module target_cmd_timer
  import target_cmd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 74_250_000
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic run,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CW-1:0] count;

  assign expired = (count == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (start) begin
      count <= '0;
    end else if (run && !expired) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/target_cmd_mailbox.sv
// Core-to-host command mailbox on the bridge; optional ack watchdog under `TARGET_CMD_TIMEOUT_EN.
// Bridge reads return one cycle after rd; req_ready is low from accept until the one-cycle DONE strobe ends.
module target_cmd_mailbox
  import target_cmd_pkg::*;
#(
  parameter int NUM_PARAMS     = 4,
  parameter int TIMEOUT_CYCLES = 74_250_000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [31:0]                bridge_addr,
  input  logic                       bridge_wr,
  input  logic [31:0]                bridge_wr_data,
  input  logic                       bridge_rd,
  output logic [31:0]                bridge_rd_data,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [15:0]                req_cmd,
  input  logic [NUM_PARAMS-1:0][31:0] req_param,
  output logic                       resp_valid,
  output logic [15:0]                resp_result,
  output logic [1:0][31:0]           resp_data,
  output logic                       busy
);

  if (NUM_PARAMS < 1 || NUM_PARAMS > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("target_cmd_mailbox: NUM_PARAMS must be 1..8 and TIMEOUT_CYCLES >= 1");
  end

  state_t                     state, state_nxt;
  logic [15:0]                cmd_q;
  logic [NUM_PARAMS-1:0][31:0] param_q;
  logic [1:0][31:0]           resp_word;
  logic [31:0]                rd_mux;
  logic [5:0]                 word;
  logic                       accept, ack_hit, timeout_hit;
  logic                       unused_addr_bits;

  assign word             = bridge_addr[7:2];
  assign unused_addr_bits = ^{bridge_addr[31:8], bridge_addr[1:0]};
  assign accept           = (state == IDLE) && req_valid;
  assign ack_hit          = bridge_wr && (word == WORD_STATUS) && (state == POSTED)
                            && (bridge_wr_data[31:16] == ACK_SIG);

`ifdef TARGET_CMD_TIMEOUT_EN
  logic expired;

  target_cmd_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .start   (accept),
    .run     (state == POSTED),
    .expired (expired)
  );

  assign timeout_hit = (state == POSTED) && expired;
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    busy       = 1'b0;
    resp_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = POSTED;
      end
      POSTED: begin
        busy = 1'b1;
        // An acknowledge in the expiry cycle takes the same path, so the host result wins
        if (ack_hit || timeout_hit) state_nxt = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        resp_valid = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rd_mux = '0;
    if (word == WORD_STATUS) begin
      if (state == POSTED) rd_mux = {CMD_SIG, cmd_q};
    end else if (word == WORD_RESP0) begin
      rd_mux = resp_word[0];
    end else if (word == WORD_RESP1) begin
      rd_mux = resp_word[1];
    end
    for (int i = 0; i < NUM_PARAMS; i++) begin
      if (word == 6'(WORD_PARAM0 + 6'(i))) rd_mux = param_q[i];
    end
  end

  // Reads sample pre-edge state, so a same-cycle write is never visible to its read
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd_q          <= '0;
      param_q        <= '0;
      resp_word      <= '0;
      resp_result    <= '0;
      resp_data      <= '0;
      bridge_rd_data <= '0;
    end else begin
      if (accept) begin
        cmd_q   <= req_cmd;
        param_q <= req_param;
      end
      if (bridge_wr && (word == WORD_RESP0)) resp_word[0] <= bridge_wr_data;
      if (bridge_wr && (word == WORD_RESP1)) resp_word[1] <= bridge_wr_data;
      if (ack_hit) begin
        resp_result <= bridge_wr_data[15:0];
        resp_data   <= resp_word;
      end else if (timeout_hit) begin
        resp_result <= RESULT_TIMEOUT;
      end
      if (bridge_rd) bridge_rd_data <= rd_mux;
    end
  end

endmodule

// File: tb/tb_target_cmd_mailbox.sv
// Directed bench for target_cmd_mailbox: bridge vector table plus request, reset and timeout sequences.
module tb_target_cmd_mailbox;

  localparam int NP = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [31:0]       bridge_addr, bridge_wr_data, bridge_rd_data;
  logic              bridge_wr, bridge_rd;
  logic              req_valid, req_ready;
  logic [15:0]       req_cmd;
  logic [NP-1:0][31:0] req_param;
  logic              resp_valid;
  logic [15:0]       resp_result;
  logic [1:0][31:0]  resp_data;
  logic              busy;

  int checks = 0;
  int passed = 0;
  int pulses = 0;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_busy;
    logic        exp_rv;
  } vec_t;

  vec_t vt[18];

  target_cmd_mailbox #(.NUM_PARAMS(NP), .TIMEOUT_CYCLES(16)) dut (
    .clk            (clk),
    .reset          (reset),
    .bridge_addr    (bridge_addr),
    .bridge_wr      (bridge_wr),
    .bridge_wr_data (bridge_wr_data),
    .bridge_rd      (bridge_rd),
    .bridge_rd_data (bridge_rd_data),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_cmd        (req_cmd),
    .req_param      (req_param),
    .resp_valid     (resp_valid),
    .resp_result    (resp_result),
    .resp_data      (resp_data),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (resp_valid === 1'b1) pulses++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    bridge_rd      = 1'b0;
    bridge_wr      = 1'b0;
    bridge_addr    = '0;
    bridge_wr_data = '0;
  endtask

  task automatic post_req(input logic [15:0] cmd, input logic [31:0] base);
    req_valid = 1'b1;
    req_cmd   = cmd;
    for (int i = 0; i < NP; i++) req_param[i] = base + 32'(i);
    step();
    req_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus_idle();
    req_valid = 1'b0;
    req_cmd   = '0;
    req_param = '0;

    //           rd    wr    addr    wdata          exp_rd         busy  rv
    vt[0]  = '{1'b1, 1'b0, 32'h00, 32'h0,         32'h636D0180, 1'b1, 1'b0};
    vt[1]  = '{1'b1, 1'b0, 32'h0C, 32'h0,         32'h00000003, 1'b1, 1'b0};
    vt[2]  = '{1'b1, 1'b0, 32'h04, 32'h0,         32'h00000001, 1'b1, 1'b0};
    vt[3]  = '{1'b1, 1'b0, 32'h10, 32'h0,         32'h00000004, 1'b1, 1'b0};
    vt[4]  = '{1'b1, 1'b0, 32'h14, 32'h0,         32'h00000000, 1'b1, 1'b0};
    vt[5]  = '{1'b0, 1'b1, 32'h04, 32'h0000FFFF,  32'h0,        1'b1, 1'b0};
    vt[6]  = '{1'b1, 1'b0, 32'h04, 32'h0,         32'h00000001, 1'b1, 1'b0};
    vt[7]  = '{1'b0, 1'b1, 32'h00, 32'h12340002,  32'h0,        1'b1, 1'b0};
    vt[8]  = '{1'b1, 1'b0, 32'h00, 32'h0,         32'h636D0180, 1'b1, 1'b0};
    vt[9]  = '{1'b0, 1'b1, 32'h80, 32'hDEAD0000,  32'h0,        1'b1, 1'b0};
    vt[10] = '{1'b1, 1'b0, 32'h80, 32'h0,         32'hDEAD0000, 1'b1, 1'b0};
    vt[11] = '{1'b1, 1'b1, 32'h84, 32'h0000BEEF,  32'h00000000, 1'b1, 1'b0};
    vt[12] = '{1'b1, 1'b0, 32'h84, 32'h0,         32'h0000BEEF, 1'b1, 1'b0};
    vt[13] = '{1'b1, 1'b0, 32'h40, 32'h0,         32'h00000000, 1'b1, 1'b0};
    vt[14] = '{1'b1, 1'b1, 32'h00, 32'h6F6B0002,  32'h636D0180, 1'b1, 1'b1};
    vt[15] = '{1'b1, 1'b0, 32'h00, 32'h0,         32'h00000000, 1'b0, 1'b0};
    vt[16] = '{1'b1, 1'b0, 32'h00, 32'h0,         32'h00000000, 1'b0, 1'b0};
    vt[17] = '{1'b0, 1'b1, 32'h00, 32'h6F6B0007,  32'h0,        1'b0, 1'b0};

    repeat (3) step();
    check("reset req_ready",   32'(req_ready),   32'd1);
    check("reset busy",        32'(busy),        32'd0);
    check("reset resp_valid",  32'(resp_valid),  32'd0);
    check("reset resp_result", 32'(resp_result), 32'd0);
    check("reset resp_data0",  resp_data[0],     32'd0);
    check("reset resp_data1",  resp_data[1],     32'd0);
    check("reset rd_data",     bridge_rd_data,   32'd0);
    reset = 1'b0;
    step();

    post_req(16'h0180, 32'd1);
    check("posted busy",      32'(busy),      32'd1);
    check("posted req_ready", 32'(req_ready), 32'd0);

    for (int i = 0; i < 18; i++) begin
      bridge_rd      = vt[i].rd;
      bridge_wr      = vt[i].wr;
      bridge_addr    = vt[i].addr;
      bridge_wr_data = vt[i].wdata;
      step();
      if (vt[i].rd) check($sformatf("vec%0d rd_data", i), bridge_rd_data, vt[i].exp_rd);
      check($sformatf("vec%0d busy", i),       32'(busy),       32'(vt[i].exp_busy));
      check($sformatf("vec%0d resp_valid", i), 32'(resp_valid), 32'(vt[i].exp_rv));
    end
    bus_idle();
    step();
    check("ack pulse count", 32'(pulses),      32'd1);
    check("ack resp_result", 32'(resp_result), 32'h0002);
    check("ack resp_data0",  resp_data[0],     32'hDEAD0000);
    check("ack resp_data1",  resp_data[1],     32'h0000BEEF);

    // Second command; a req_valid held into POSTED must not overwrite it
    req_valid = 1'b1;
    req_cmd   = 16'h0222;
    for (int i = 0; i < NP; i++) req_param[i] = 32'd5 + 32'(i);
    check("idle req_ready", 32'(req_ready), 32'd1);
    step();
    req_cmd   = 16'h0333;
    req_param = '0;
    step();
    req_valid = 1'b0;
    check("held req busy", 32'(busy), 32'd1);
    bridge_rd = 1'b1; bridge_addr = 32'h00;
    step();
    check("second cmd status", bridge_rd_data, 32'h636D0222);
    bridge_addr = 32'h10;
    step();
    check("second cmd param3", bridge_rd_data, 32'h00000008);
    bus_idle();

    // Reset mid-POSTED, away from any clock edge
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("midreset busy",      32'(busy),      32'd0);
    check("midreset req_ready", 32'(req_ready), 32'd1);
    check("midreset rd_data",   bridge_rd_data, 32'd0);
    check("midreset result",    32'(resp_result), 32'd0);
    check("midreset data0",     resp_data[0],   32'd0);
    step();
    reset = 1'b0;
    repeat (5) step();
    check("midreset no pulse", 32'(pulses), 32'd1);
    bridge_rd = 1'b1; bridge_addr = 32'h04;
    step();
    check("midreset param0", bridge_rd_data, 32'd0);
    bridge_addr = 32'h00;
    step();
    check("midreset status", bridge_rd_data, 32'd0);
    bus_idle();
    step();

`ifdef TARGET_CMD_TIMEOUT_EN
    post_req(16'h0444, 32'd9);
    repeat (15) step();
    check("timeout early rv", 32'(resp_valid), 32'd0);
    step();
    check("timeout rv",     32'(resp_valid),  32'd1);
    check("timeout result", 32'(resp_result), 32'hFFFF);
    check("timeout data0",  resp_data[0],     32'd0);
    step();
    step();

    post_req(16'h0555, 32'd9);
    repeat (15) step();
    check("late ack early rv", 32'(resp_valid), 32'd0);
    bridge_wr = 1'b1; bridge_addr = 32'h00; bridge_wr_data = 32'h6F6B0055;
    step();
    bus_idle();
    check("late ack rv",     32'(resp_valid),  32'd1);
    check("late ack result", 32'(resp_result), 32'h0055);
    step();
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
